div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- EX-stage initiator for the iterative HI/LO divider.
- Accepts DIV/DIVU from EX, drives the divider's start/annul/signed/operand interface, and stalls the pipeline while the divide runs.
- Writes the quotient/remainder to the HI/LO register, aborts cleanly on pipeline flush, and keeps a divide-cycle performance counter.

Parameters:
DRAIN_CYCLES, 2, cycles div_start is held low after an abort before a new issue is allowed (divider needs ByZero->End->Free).
PERF_W, 32, width of the divide busy-cycle performance counter.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
ex_div_valid  in  1  EX holds a DIV/DIVU instruction
ex_div_signed  in  1  1 = DIV, 0 = DIVU
ex_rs_data  in  32  dividend
ex_rt_data  in  32  divisor
ex_flush  in  1  exception/flush; kills the EX instruction
stall_req  out  1  stall IF..EX (combinational)
hilo_we  out  1  one-cycle HI/LO write strobe
hilo_hi  out  32  remainder to HI
hilo_lo  out  32  quotient to LO
div_start  out  1  divider start, held high for the whole operation
div_annul  out  1  divider abort
div_signed  out  1  divider signed mode
div_op1  out  32  divider dividend (registered)
div_op2  out  32  divider divisor (registered)
div_hi  in  32  divider remainder
div_lo  in  32  divider quotient
div_busy  in  1  divider busy; low while div_start=1 means div_hi/div_lo are valid this cycle
perf_div_cycles  out  PERF_W  count of cycles spent in RUN

Behaviour:
- Divider contract:
  - Requests are level-held on div_start. Operands and div_signed must stay stable until div_busy falls.
  - div_start low in the End state returns the divider to Free on the next edge.
  - div_annul is honoured only while the divider is iterating.
  - A zero divisor yields hi=0, lo=0. Normal latency is about 35 cycles from start.
- Reset (async): state=IDLE.
  - div_start=0, div_annul=0, div_signed=0, div_op1=div_op2=0.
  - hilo_we=0, hilo_hi=hilo_lo=0, drain counter=0, perf_div_cycles=0.
- States: IDLE, RUN, DONE, DRAIN.
- IDLE:
  - If ex_div_valid & ~ex_flush: latch ex_rs_data->div_op1, ex_rt_data->div_op2, ex_div_signed->div_signed; set div_start=1; go RUN.
  - stall_req = ex_div_valid & ~ex_flush.
- RUN:
  - div_start held at 1. perf_div_cycles increments every cycle, wrapping at 2^PERF_W.
  - ex_flush=1 (priority over completion): div_annul=1 for exactly this cycle, div_start=0, drain counter=DRAIN_CYCLES, go DRAIN. No hilo_we. stall_req=0.
  - Else div_busy=0: register hilo_hi<=div_hi, hilo_lo<=div_lo, hilo_we<=1 (asserted next cycle, for one cycle); div_start<=0; go DONE. stall_req=0 this cycle so the instruction advances.
  - Else: stall_req=1.
- DONE: hilo_we=1 for this cycle only; div_start=0 so the divider returns to Free. stall_req = ex_div_valid. Go IDLE.
- DRAIN:
  - div_start=0. Decrement the counter; go IDLE when it reaches 1.
  - stall_req = ex_div_valid & ~ex_flush.
- Outputs other than stall_req are registered. stall_req is a combinational function of state, ex_div_valid, ex_flush and div_busy only.
- ex_div_valid changes in RUN are ignored; the latched operands are used.
- ex_flush in IDLE/DONE/DRAIN: no issue that cycle; no other effect.
- Reset mid-RUN: the controller returns to IDLE immediately. The divider is reset by the same rst.

Test Plan:
- DIVU 100/7 -> stall_req high from issue until div_busy falls; one hilo_we with hi=2, lo=14; perf_div_cycles equal to the RUN duration (about 35).
- DIV 0xFFFFFFF9/2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD; div_signed=1 held throughout RUN.
- DIVU 5/0 -> completes through the divider's by-zero path; hilo_we with hi=0, lo=0; no hang.
- Flush 10 cycles into a divide -> one div_annul pulse, div_start low, no hilo_we. The next DIVU 9/3 waits DRAIN_CYCLES, then gives hi=0, lo=3.
- Back-to-back DIVU 8/2 then 7/7 -> two hilo_we pulses (lo=4 then lo=1); the second issue waits one cycle after DONE.
- Assert rst mid-RUN -> all outputs return to reset values asynchronously; after release a DIVU 1/1 yields hi=0, lo=1.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the iterative HI/LO divider: issues DIV/DIVU,
// stalls the pipeline while the divide runs, writes HI/LO and handles flush aborts.
module div_issue_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_div_valid,
  input  logic              ex_div_signed,
  input  logic [31:0]       ex_rs_data,
  input  logic [31:0]       ex_rt_data,
  input  logic              ex_flush,
  output logic              stall_req,
  output logic              hilo_we,
  output logic [31:0]       hilo_hi,
  output logic [31:0]       hilo_lo,
  output logic              div_start,
  output logic              div_annul,
  output logic              div_signed,
  output logic [31:0]       div_op1,
  output logic [31:0]       div_op2,
  input  logic [31:0]       div_hi,
  input  logic [31:0]       div_lo,
  input  logic              div_busy,
  output logic [PERF_W-1:0] perf_div_cycles
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  logic [1:0]        state_q, state_d;
  logic              start_q, start_d;
  logic              annul_q, annul_d;
  logic              signed_q, signed_d;
  logic [31:0]       op1_q, op1_d, op2_q, op2_d;
  logic              we_q, we_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    annul_d  = 1'b0;
    signed_d = signed_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    we_d     = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    drain_d  = drain_q;
    perf_d   = perf_q;
    case (state_q)
      S_IDLE: begin
        if (ex_div_valid && !ex_flush) begin
          op1_d    = ex_rs_data;
          op2_d    = ex_rt_data;
          signed_d = ex_div_signed;
          start_d  = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        perf_d = perf_q + PERF_W'(1);
        // Flush wins over a same-cycle completion: the result is discarded.
        if (ex_flush) begin
          annul_d = 1'b1;
          start_d = 1'b0;
          drain_d = DW'(DRAIN_CYCLES);
          state_d = S_DRAIN;
        end else if (!div_busy) begin
          hi_d    = div_hi;
          lo_d    = div_lo;
          we_d    = 1'b1;
          start_d = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        // Keep div_start low long enough for the divider to walk back to Free.
        start_d = 1'b0;
        drain_d = drain_q - DW'(1);
        if (drain_q <= DW'(1)) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      annul_q  <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      we_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      drain_q  <= '0;
      perf_q   <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      annul_q  <= annul_d;
      signed_q <= signed_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      we_q     <= we_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      drain_q  <= drain_d;
      perf_q   <= perf_d;
    end
  end

  always_comb begin
    stall_req = 1'b0;
    case (state_q)
      S_IDLE:  stall_req = ex_div_valid && !ex_flush;
      S_RUN:   stall_req = div_busy && !ex_flush;
      S_DONE:  stall_req = ex_div_valid;
      default: stall_req = ex_div_valid && !ex_flush;
    endcase
  end

  assign div_start       = start_q;
  assign div_annul       = annul_q;
  assign div_signed      = signed_q;
  assign div_op1         = op1_q;
  assign div_op2         = op2_q;
  assign hilo_we         = we_q;
  assign hilo_hi         = hi_q;
  assign hilo_lo         = lo_q;
  assign perf_div_cycles = perf_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider and a per-cycle
// result scoreboard; stall and perf expectations are hand-computed per vector.
module tb_div_issue_ctrl;
  localparam int DRAIN = 2;
  localparam int LAT   = 34;   // divider busy cycles after start for a nonzero divisor
  localparam int LAT0  = 2;    // by-zero path

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ex_div_valid = 1'b0, ex_div_signed = 1'b0, ex_flush = 1'b0;
  logic [31:0] ex_rs_data = '0, ex_rt_data = '0;
  logic stall_req, hilo_we, div_start, div_annul, div_signed, div_busy;
  logic [31:0] hilo_hi, hilo_lo, div_op1, div_op2, div_hi, div_lo;
  logic [31:0] perf_div_cycles;

  div_issue_ctrl #(.DRAIN_CYCLES(DRAIN), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .ex_div_valid(ex_div_valid), .ex_div_signed(ex_div_signed),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_flush(ex_flush),
    .stall_req(stall_req), .hilo_we(hilo_we), .hilo_hi(hilo_hi), .hilo_lo(hilo_lo),
    .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
    .div_op1(div_op1), .div_op2(div_op2), .div_hi(div_hi), .div_lo(div_lo),
    .div_busy(div_busy), .perf_div_cycles(perf_div_cycles));

  always #5 clk = ~clk;

  // Behavioural divider: busy for a fixed count of cycles while start is held.
  int dcnt, dlat;
  assign dlat = (div_op2 == 32'd0) ? LAT0 : LAT;
  always @(posedge clk or posedge rst) begin
    if (rst) dcnt <= 0;
    else if (!div_start) dcnt <= 0;
    else if (dcnt < dlat) dcnt <= dcnt + 1;
  end
  assign div_busy = div_start && (dcnt < dlat);
  always_comb begin
    div_hi = '0;
    div_lo = '0;
    if (div_op2 != 32'd0) begin
      if (div_signed) begin
        div_lo = $signed(div_op1) / $signed(div_op2);
        div_hi = $signed(div_op1) % $signed(div_op2);
      end else begin
        div_lo = div_op1 / div_op2;
        div_hi = div_op1 % div_op2;
      end
    end
  end

  int n_tests = 0, n_fail = 0, annul_cnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_op1 = '0, cur_op2 = '0;
  logic cur_sgn = 1'b0, we_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every HI/LO write must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (rst) we_prev = 1'b0;
    else begin
      if (hilo_we) begin
        chk("hilo_we_single_cycle", {63'd0, we_prev}, 64'd0);
        if (exp_q.size() == 0) chk("hilo_we_unexpected", 64'd1, 64'd0);
        else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("hilo_hi", {32'd0, hilo_hi}, {32'd0, e[63:32]});
          chk("hilo_lo", {32'd0, hilo_lo}, {32'd0, e[31:0]});
        end
      end
      if (div_start) begin
        chk("div_op1_stable", {32'd0, div_op1}, {32'd0, cur_op1});
        chk("div_op2_stable", {32'd0, div_op2}, {32'd0, cur_op2});
        chk("div_signed_stable", {63'd0, div_signed}, {63'd0, cur_sgn});
      end
      if (div_annul) begin
        annul_cnt++;
        chk("annul_start_low", {63'd0, div_start}, 64'd0);
      end
      we_prev = hilo_we;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_start"},  {63'd0, div_start}, 64'd0);
    chk({tag, "_annul"},  {63'd0, div_annul}, 64'd0);
    chk({tag, "_signed"}, {63'd0, div_signed}, 64'd0);
    chk({tag, "_op1"},    {32'd0, div_op1}, 64'd0);
    chk({tag, "_op2"},    {32'd0, div_op2}, 64'd0);
    chk({tag, "_we"},     {63'd0, hilo_we}, 64'd0);
    chk({tag, "_hi"},     {32'd0, hilo_hi}, 64'd0);
    chk({tag, "_lo"},     {32'd0, hilo_lo}, 64'd0);
    chk({tag, "_perf"},   {32'd0, perf_div_cycles}, 64'd0);
    chk({tag, "_stall"},  {63'd0, stall_req}, 64'd0);
  endtask

  // Called just after a rising edge; returns just after the edge on which EX advances.
  task automatic divu(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                      input logic [31:0] ehi, input logic [31:0] elo,
                      input int estall, input int eperf, input bit chain, input string name);
    int n;
    bit done;
    logic [31:0] p0;
    cur_op1 = a; cur_op2 = b; cur_sgn = sgn;
    ex_rs_data = a; ex_rt_data = b; ex_div_signed = sgn; ex_div_valid = 1'b1;
    exp_q.push_back({ehi, elo});
    p0 = perf_div_cycles;
    n = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (stall_req) n++;
      else done = 1;
    end
    if (!done) begin
      $display("FAIL %s_timeout: stall_req still high after 200 cycles, required low", name);
      n_fail++;
      n_tests++;
    end
    @(posedge clk);
    #1;
    if (!chain) ex_div_valid = 1'b0;
    chk({name, "_stall_cycles"}, 64'(n), 64'(estall));
    chk({name, "_perf"}, {32'd0, perf_div_cycles - p0}, 64'(eperf));
    chk({name, "_we_now"}, {63'd0, hilo_we}, 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    divu(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, LAT + 1, LAT + 1, 1'b0, "divu_100_7");
    @(posedge clk); #1;
    divu(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT + 1, LAT + 1, 1'b0, "div_m7_2");
    @(posedge clk); #1;
    divu(32'd5, 32'd0, 1'b0, 32'd0, 32'd0, LAT0 + 1, LAT0 + 1, 1'b0, "divu_5_0");
    @(posedge clk); #1;

    // Flush ten cycles into a divide, then queue a new DIVU straight into the drain window.
    cur_op1 = 32'd100; cur_op2 = 32'd3; cur_sgn = 1'b0;
    ex_rs_data = 32'd100; ex_rt_data = 32'd3; ex_div_signed = 1'b0; ex_div_valid = 1'b1;
    for (int i = 0; i < 20 && !div_start; i++) @(negedge clk);
    repeat (9) @(negedge clk);
    #1 ex_flush = 1'b1;
    #1 chk("flush_stall", {63'd0, stall_req}, 64'd0);
    @(posedge clk); #1;
    ex_flush = 1'b0;
    chk("flush_annul", {63'd0, div_annul}, 64'd1);
    chk("flush_start_low", {63'd0, div_start}, 64'd0);
    chk("flush_no_we", {63'd0, hilo_we}, 64'd0);
    divu(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, DRAIN + LAT + 1, LAT + 1, 1'b0, "divu_9_3_after_flush");
    @(posedge clk); #1;

    divu(32'd8, 32'd2, 1'b0, 32'd0, 32'd4, LAT + 1, LAT + 1, 1'b1, "b2b_8_2");
    divu(32'd7, 32'd7, 1'b0, 32'd0, 32'd1, LAT + 2, LAT + 1, 1'b0, "b2b_7_7");
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a divide.
    cur_op1 = 32'd50; cur_op2 = 32'd5; cur_sgn = 1'b1;
    ex_rs_data = 32'd50; ex_rt_data = 32'd5; ex_div_signed = 1'b1; ex_div_valid = 1'b1;
    for (int i = 0; i < 20 && !div_start; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    ex_div_valid = 1'b0;
    #1 chk_reset("midrun_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    divu(32'd1, 32'd1, 1'b0, 32'd0, 32'd1, LAT + 1, LAT + 1, 1'b0, "divu_1_1_after_reset");

    repeat (3) @(negedge clk);
    chk("results_outstanding", 64'(exp_q.size()), 64'd0);
    chk("annul_pulses", 64'(annul_cnt), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
endmodule
